// File: rtl/alu_pkg.sv
// Shared ALU opcode, control-word and sequencer state definitions.
// Imported by the sequencer, its control decoder and future control units.
package alu_pkg;

  localparam int CTRL_W = 12;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_SHR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_ROR = 4'd6;
  localparam logic [3:0] OP_ROL = 4'd7;
  localparam logic [3:0] OP_AND = 4'd8;
  localparam logic [3:0] OP_OR  = 4'd9;
  localparam logic [3:0] OP_NEG = 4'd10;
  localparam logic [3:0] OP_NOT = 4'd11;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  function automatic logic op_is_legal(
    input logic [3:0] op
  );
    return op <= OP_NOT;
  endfunction

  function automatic logic op_is_muldiv(
    input logic [3:0] op
  );
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request and result handshakes between an operation source
// and the ALU operation sequencer.
interface alu_op_sequencer_if #(
  parameter int BITS = 32
);

  logic            req_valid;
  logic            req_ready;
  logic [3:0]      req_op;
  logic [BITS-1:0] req_x;
  logic [BITS-1:0] req_y;

  logic            res_valid;
  logic            res_ready;
  logic [BITS-1:0] res_lo;
  logic [BITS-1:0] res_hi;
  logic            res_err;

  modport master (
    output req_valid,
    output req_op,
    output req_x,
    output req_y,
    output res_ready,
    input  req_ready,
    input  res_valid,
    input  res_lo,
    input  res_hi,
    input  res_err
  );

  modport slave (
    input  req_valid,
    input  req_op,
    input  req_x,
    input  req_y,
    input  res_ready,
    output req_ready,
    output res_valid,
    output res_lo,
    output res_hi,
    output res_err
  );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Binary opcode to one-hot ALU control word.
// Produces an all-zero word when disabled or for illegal opcodes.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic              en,
  input  logic [3:0]        op,
  output logic [CTRL_W-1:0] ctrl
);

  always_comb begin
    ctrl = '0;
    for (int i = 0; i < CTRL_W; i++) begin
      ctrl[i] = en && (op == 4'(i));
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer feeding a combinational ALU and
// returning its 2*BITS result through a valid/ready handshake.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int BITS          = 32,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic                clk,
  input  logic                clr,
  alu_op_sequencer_if.slave   bus,
  output logic [CTRL_W-1:0]   alu_ctrl,
  output logic [BITS-1:0]     alu_x,
  output logic [BITS-1:0]     alu_y,
  input  logic [2*BITS-1:0]   alu_result
);

  localparam int CW = $clog2(MULDIV_CYCLES) + 1;

  state_t            state;
  logic [3:0]        op_q;
  logic [BITS-1:0]   x_q;
  logic [BITS-1:0]   y_q;
  logic [2*BITS-1:0] z_q;
  logic              err_q;
  logic [CW-1:0]     cnt;
  logic              exec;
  logic              ok;

  assign exec = (state == EXEC);

  // Divide-by-zero is rejected before the ALU ever sees it.
  assign ok = op_is_legal(bus.req_op) &&
              !((bus.req_op == OP_DIV) &&
                (bus.req_y == '0));

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      op_q  <= '0;
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      err_q <= 1'b0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_q <= bus.req_op;
            x_q  <= bus.req_x;
            y_q  <= bus.req_y;
            if (ok) begin
              cnt <= op_is_muldiv(bus.req_op)
                   ? CW'(MULDIV_CYCLES - 1)
                   : '0;
              state <= EXEC;
            end else begin
              z_q   <= '0;
              err_q <= 1'b1;
              state <= RESP;
            end
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            z_q   <= alu_result;
            err_q <= 1'b0;
            state <= RESP;
          end
        end
        RESP: begin
          if (bus.res_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  alu_ctrl_decode u_dec (
    .en   (exec),
    .op   (op_q),
    .ctrl (alu_ctrl)
  );

  assign alu_x = exec ? x_q : '0;
  assign alu_y = exec ? y_q : '0;

  assign bus.req_ready = (state == IDLE) && !clr;
  assign bus.res_valid = (state == RESP);
  assign bus.res_lo    = z_q[BITS-1:0];
  assign bus.res_hi    = z_q[2*BITS-1:BITS];
  assign bus.res_err   = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed scoreboard bench for alu_op_sequencer with a
// behavioural ALU stub driven by the one-hot control word.
module tb_alu_op_sequencer;

  localparam int BITS = 32;
  localparam int MDC  = 4;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        err;
  } exp_t;

  logic        clk;
  logic        clr;
  logic [11:0] alu_ctrl;
  logic [31:0] alu_x;
  logic [31:0] alu_y;
  logic [63:0] alu_result;

  int   vec_n;
  int   err_n;
  bit   mon_on;
  exp_t sb[$];

  alu_op_sequencer_if #(.BITS(BITS)) bus ();

  alu_op_sequencer #(
    .BITS          (BITS),
    .MULDIV_CYCLES (MDC)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .bus        (bus.slave),
    .alu_ctrl   (alu_ctrl),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_result (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    alu_result = '0;
    unique case (1'b1)
      alu_ctrl[0]:  alu_result = {32'b0, alu_x + alu_y};
      alu_ctrl[1]:  alu_result = {32'b0, alu_x - alu_y};
      alu_ctrl[2]:  alu_result = 64'(alu_x) * 64'(alu_y);
      alu_ctrl[3]:  alu_result = (alu_y == 0) ? 64'b0 :
                      {alu_x % alu_y, alu_x / alu_y};
      alu_ctrl[4]:  alu_result = {32'b0, alu_x >> alu_y[4:0]};
      alu_ctrl[5]:  alu_result = {32'b0, alu_x << alu_y[4:0]};
      alu_ctrl[8]:  alu_result = {32'b0, alu_x & alu_y};
      alu_ctrl[9]:  alu_result = {32'b0, alu_x | alu_y};
      alu_ctrl[10]: alu_result = {32'b0, -alu_x};
      alu_ctrl[11]: alu_result = {32'b0, ~alu_x};
      default:      alu_result = '0;
    endcase
  end

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    vec_n++;
    assert (obs === exp) else begin
      err_n++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on)
      chk("onehot0", 64'($onehot0(alu_ctrl)), 64'd1);
  end

  task automatic send(
    input logic [3:0]  op,
    input logic [31:0] x,
    input logic [31:0] y,
    input bit          push,
    input exp_t        e
  );
    int n;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_x     = x;
    bus.req_y     = y;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("req_timeout", 64'(n), 64'd0);
    if (push) sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_res(
    input string       tag,
    input logic [11:0] ctl,
    input logic [31:0] x,
    input logic [31:0] y,
    input int          lat,
    input int          ctl_cyc
  );
    int n;
    int c;
    n = 0;
    c = 0;
    while (!bus.res_valid && n < 40) begin
      if (alu_ctrl != '0) begin
        c++;
        chk({tag, "_ctrl"}, 64'(alu_ctrl), 64'(ctl));
        chk({tag, "_x"}, 64'(alu_x), 64'(x));
        chk({tag, "_y"}, 64'(alu_y), 64'(y));
      end
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 64'(bus.res_valid), 64'd1);
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_ctlcyc"}, 64'(c), 64'(ctl_cyc));
    chk({tag, "_ctl_off"}, 64'(alu_ctrl), 64'd0);
  endtask

  task automatic take(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_lo"}, 64'(bus.res_lo), 64'(e.lo));
      chk({tag, "_hi"}, 64'(bus.res_hi), 64'(e.hi));
      chk({tag, "_err"}, 64'(bus.res_err), 64'(e.err));
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk({tag, "_done_v"}, 64'(bus.res_valid), 64'd0);
    chk({tag, "_rdy"}, 64'(bus.req_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] lo0;
    logic [31:0] hi0;
    int          seen;
    vec_n         = 0;
    err_n         = 0;
    mon_on        = 1'b0;
    clr           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.res_ready = 1'b0;

    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_res", {bus.res_hi, bus.res_lo}, 64'd0);
    chk("rst_err", 64'(bus.res_err), 64'd0);
    chk("rst_ctrl", 64'(alu_ctrl), 64'd0);
    chk("rst_xy", {alu_x, alu_y}, 64'd0);
    clr    = 1'b0;
    mon_on = 1'b1;
    @(negedge clk);
    chk("rst_rel_ready", 64'(bus.req_ready), 64'd1);

    send(4'd0, 32'd3, 32'd5, 1, '{32'd8, 32'd0, 1'b0});
    wait_res("add", 12'h001, 32'd3, 32'd5, 1, 1);
    take("add");

    send(4'd8, 32'hFFFF_FFFF, 32'd0, 1,
         '{32'd0, 32'd0, 1'b0});
    wait_res("and", 12'h100, 32'hFFFF_FFFF, 32'd0, 1, 1);
    take("and");

    send(4'd9, 32'hFFFF_FFFF, 32'd0, 1,
         '{32'hFFFF_FFFF, 32'd0, 1'b0});
    wait_res("or", 12'h200, 32'hFFFF_FFFF, 32'd0, 1, 1);
    take("or");

    send(4'd2, 32'h0001_0000, 32'h0001_0000, 1,
         '{32'd0, 32'd1, 1'b0});
    wait_res("mul", 12'h004, 32'h0001_0000,
             32'h0001_0000, MDC, MDC);
    take("mul");

    send(4'd3, 32'd100, 32'd7, 1, '{32'd14, 32'd2, 1'b0});
    wait_res("div", 12'h008, 32'd100, 32'd7, MDC, MDC);
    take("div");

    send(4'd3, 32'd9, 32'd0, 1, '{32'd0, 32'd0, 1'b1});
    wait_res("div0", 12'h000, 32'd0, 32'd0, 0, 0);
    take("div0");

    send(4'd13, 32'd1, 32'd2, 1, '{32'd0, 32'd0, 1'b1});
    wait_res("ill", 12'h000, 32'd0, 32'd0, 0, 0);
    take("ill");

    send(4'd1, 32'd10, 32'd3, 1, '{32'd7, 32'd0, 1'b0});
    wait_res("bp", 12'h002, 32'd10, 32'd3, 1, 1);
    lo0 = bus.res_lo;
    hi0 = bus.res_hi;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(bus.res_valid), 64'd1);
      chk("bp_stable", {bus.res_hi, bus.res_lo},
          {hi0, lo0});
      chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
    end
    take("bp");

    send(4'd10, 32'd1, 32'd0, 1,
         '{32'hFFFF_FFFF, 32'd0, 1'b0});
    wait_res("b2b", 12'h400, 32'd1, 32'd0, 1, 1);
    take("b2b");

    send(4'd2, 32'd6, 32'd7, 0, '{32'd0, 32'd0, 1'b0});
    @(negedge clk);
    chk("clr_exec2", 64'(alu_ctrl), 64'h004);
    clr = 1'b1;
    @(negedge clk);
    chk("clr_ctrl", 64'(alu_ctrl), 64'd0);
    chk("clr_valid", 64'(bus.res_valid), 64'd0);
    chk("clr_req_ready", 64'(bus.req_ready), 64'd0);
    clr  = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.res_valid) seen++;
    end
    chk("clr_no_resp", 64'(seen), 64'd0);
    chk("clr_idle", 64'(bus.req_ready), 64'd1);

    send(4'd0, 32'd3, 32'd5, 1, '{32'd8, 32'd0, 1'b0});
    wait_res("post", 12'h001, 32'd3, 32'd5, 1, 1);
    take("post");

    chk("sb_drained", 64'(sb.size()), 64'd0);
    mon_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vec_n, err_n);
    $finish;
  end

endmodule
